// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants: security level encodings, w1 packing widths and limits.
package dilithium_pkg;

    localparam int unsigned SEC_LVL_W = 3;
    localparam logic [SEC_LVL_W-1:0] SEC_LVL_2 = 3'd2;
    localparam logic [SEC_LVL_W-1:0] SEC_LVL_3 = 3'd3;
    localparam logic [SEC_LVL_W-1:0] SEC_LVL_5 = 3'd5;

    localparam int unsigned Q = 8380417;

    localparam int unsigned R1_IN_W   = 24;
    localparam int unsigned W1_W_L2   = 6;
    localparam int unsigned W1_W_L35  = 4;
    localparam int unsigned W1_W_MAX  = 6;

    localparam int unsigned R1_MAX_L2  = 43;
    localparam int unsigned R1_MAX_L35 = 15;

    localparam int unsigned WORDS_L2  = 24;
    localparam int unsigned WORDS_L35 = 16;

    // Levels 3 and 5 share the 4-bit w1 encoding; everything else packs as level 2.
    function automatic logic lvl_is_w4(input logic [SEC_LVL_W-1:0] lvl);
        return (lvl == SEC_LVL_3) || (lvl == SEC_LVL_5);
    endfunction

    function automatic logic lvl_is_valid(input logic [SEC_LVL_W-1:0] lvl);
        return (lvl == SEC_LVL_2) || lvl_is_w4(lvl);
    endfunction

endpackage

// File: rtl/w1_packer.sv
// Packs r1 coefficients (4 or 6 bits each) into 64-bit words in SimpleBitPack order.
module w1_packer
    import dilithium_pkg::*;
#(
    parameter int unsigned N  = 256,
    parameter int unsigned DW = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEC_LVL_W-1:0] sec_lvl,
    input  logic                 valid_i,
    output logic                 ready_i,
    input  logic [R1_IN_W-1:0]   di,
    output logic [DW-1:0]        do_o,
    output logic                 valid_o,
    input  logic                 ready_o,
    output logic                 last_o,
    output logic                 err_o
);

    localparam int unsigned BUF_W  = DW + W1_W_MAX;
    localparam int unsigned CNT_W  = $clog2(BUF_W);
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned WORD_W = $clog2(WORDS_L2);

    logic [BUF_W-1:0]     buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [SEC_LVL_W-1:0] lvl_q, lvl_d;
    logic [DW-1:0]        do_q, do_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 drain;
    logic                 first;
    logic                 eff_w4;
    logic                 bad;
    logic [SEC_LVL_W-1:0] lvl_eff;
    logic [BUF_W-1:0]     coef_ext;
    logic [WORD_W-1:0]    word_last;

    // Next-state: fill and drain are mutually exclusive via the cnt threshold.
    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        word_d   = word_q;
        lvl_d    = lvl_q;
        do_d     = do_q;
        valid_d  = valid_q;
        last_d   = last_q;
        err_d    = err_q;
        coef_ext = '0;
        bad      = 1'b0;

        ready_i   = !rst && (cnt_q < CNT_W'(DW));
        accept    = valid_i && ready_i;
        drain     = (cnt_q >= CNT_W'(DW)) && (!valid_q || ready_o);
        first     = (idx_q == '0);
        lvl_eff   = first ? sec_lvl : lvl_q;
        eff_w4    = lvl_is_w4(lvl_eff);
        word_last = lvl_is_w4(lvl_q) ? WORD_W'(WORDS_L35 - 1) : WORD_W'(WORDS_L2 - 1);

        if (accept) begin
            if (eff_w4) begin
                coef_ext = BUF_W'(di[W1_W_L35-1:0]);
                cnt_d    = cnt_q + CNT_W'(W1_W_L35);
                bad      = di > R1_IN_W'(R1_MAX_L35);
            end else begin
                coef_ext = BUF_W'(di[W1_W_L2-1:0]);
                cnt_d    = cnt_q + CNT_W'(W1_W_L2);
                bad      = di > R1_IN_W'(R1_MAX_L2);
            end
            // Bits at and above cnt are always zero, so OR-in is a plain insert.
            buf_d = buf_q | (coef_ext << cnt_q);
            idx_d = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
            if (first) begin
                lvl_d = sec_lvl;
                if (!lvl_is_valid(sec_lvl)) begin
                    bad = 1'b1;
                end
            end
            if (bad) begin
                err_d = 1'b1;
            end
        end

        if (drain) begin
            do_d    = buf_q[DW-1:0];
            valid_d = 1'b1;
            buf_d   = buf_q >> DW;
            cnt_d   = cnt_q - CNT_W'(DW);
            last_d  = (word_q == word_last);
            word_d  = (word_q == word_last) ? '0 : word_q + WORD_W'(1);
        end else if (valid_q && ready_o) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            lvl_q   <= '0;
            do_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            lvl_q   <= lvl_d;
            do_q    <= do_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign do_o    = do_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_w1_packer.sv
// Bench for w1_packer: table of whole-polynomial vectors, hand sequences, random traffic vs a bit-stream model.
module tb_w1_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sec_lvl;
    logic        valid_i;
    logic        ready_i;
    logic [23:0] di;
    logic [63:0] do_o;
    logic        valid_o;
    logic        ready_o;
    logic        last_o;
    logic        err_o;

    always #5 clk = ~clk;

    w1_packer #(.N(256), .DW(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .sec_lvl (sec_lvl),
        .valid_i (valid_i),
        .ready_i (ready_i),
        .di      (di),
        .do_o    (do_o),
        .valid_o (valid_o),
        .ready_o (ready_o),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check32(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: coefficient i occupies stream bits W*i..W*i+W-1; word k is bits 64k..64k+63.
    typedef struct packed {
        logic [63:0] w;
        logic        last;
    } exp_t;

    logic [23:0] m_coef [256];
    int          m_idx   = 0;
    int          m_words = 0;
    int          m_w     = 6;
    bit          m_err   = 1'b0;
    exp_t        exp_q[$];

    function automatic void model_reset();
        m_idx   = 0;
        m_words = 0;
        m_err   = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_accept(input logic [23:0] d, input logic [2:0] s);
        int mx;
        int nw;
        if (m_idx == 0) begin
            m_w = (s == 3'd3 || s == 3'd5) ? 4 : 6;
            if (!(s == 3'd2 || s == 3'd3 || s == 3'd5)) m_err = 1'b1;
        end
        mx = (m_w == 4) ? 15 : 43;
        if (d > 24'(mx)) m_err = 1'b1;
        m_coef[m_idx] = d;
        m_idx++;
        nw = 256 * m_w / 64;
        while ((m_words + 1) * 64 <= m_idx * m_w) begin
            exp_t e;
            e.w = '0;
            for (int b = 0; b < 64; b++) begin
                int pos = m_words * 64 + b;
                e.w[b] = m_coef[pos / m_w][pos % m_w];
            end
            e.last = (m_words == nw - 1);
            exp_q.push_back(e);
            m_words++;
        end
        if (m_idx == 256) begin
            m_idx   = 0;
            m_words = 0;
        end
    endfunction

    int          out_count;
    int          last_count;
    int          last_pos;
    logic [63:0] out_w0;
    logic [63:0] out_w1;
    bit          prev_hold = 1'b0;
    logic [63:0] prev_do;
    logic        prev_last;

    logic [23:0] coefs [256];
    logic [2:0]  lvls  [256];

    function automatic void clear_stats();
        out_count  = 0;
        last_count = 0;
        last_pos   = -1;
        out_w0     = '0;
        out_w1     = '0;
    endfunction

    function automatic void set_poly(input logic [2:0] lvl, input int mode, input logic [23:0] fill);
        for (int i = 0; i < 256; i++) begin
            coefs[i] = (mode == 1) ? 24'(i % 16) : fill;
            lvls[i]  = lvl;
        end
    endfunction

    // One clock: inputs already driven at the falling edge; sample, score, advance.
    task automatic cycle(output bit acc);
        #1;
        acc = 1'b0;
        check1("err_o", err_o, m_err);
        if (prev_hold) begin
            check1("hold_valid", valid_o, 1'b1);
            check64("hold_do", do_o, prev_do);
            check1("hold_last", last_o, prev_last);
        end
        if (valid_o && ready_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_word: got %h, expected no word", do_o);
            end else begin
                exp_t e = exp_q.pop_front();
                check64("word", do_o, e.w);
                check1("last", last_o, e.last);
            end
            if (out_count == 0) out_w0 = do_o;
            if (out_count == 1) out_w1 = do_o;
            if (last_o) begin
                last_count++;
                last_pos = out_count;
            end
            out_count++;
        end
        if (valid_i && ready_i) begin
            model_accept(di, sec_lvl);
            acc = 1'b1;
        end
        prev_hold = valid_o && !ready_o;
        prev_do   = do_o;
        prev_last = last_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_o = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check1("ready_in_rst", ready_i, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prev_hold = 1'b0;
    endtask

    task automatic check_reset_vals();
        #1;
        check64("rst_do", do_o, 64'h0);
        check1("rst_valid", valid_o, 1'b0);
        check1("rst_last", last_o, 1'b0);
        check1("rst_err", err_o, 1'b0);
        check1("rst_ready", ready_i, 1'b1);
    endtask

    task automatic step(inout int idx, input bit vrnd, input bit rrnd, input bit rdy);
        bit acc;
        if (idx < 256) begin
            di      = coefs[idx];
            sec_lvl = lvls[idx];
            valid_i = vrnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
            di      = '0;
            valid_i = 1'b0;
        end
        ready_o = rrnd ? ($urandom_range(0, 2) != 0) : rdy;
        cycle(acc);
        if (acc) idx++;
    endtask

    task automatic feed(input int start, input bit vrnd, input bit rrnd, output int cycles);
        int idx;
        idx    = start;
        cycles = 0;
        while (idx < 256 && cycles < 5000) begin
            step(idx, vrnd, rrnd, 1'b1);
            cycles++;
        end
        check32("feed_done", idx, 256);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        int idx;
        n   = 0;
        idx = 256;
        while ((exp_q.size() != 0 || valid_o) && n < 500) begin
            step(idx, 1'b0, 1'b0, 1'b1);
            n++;
        end
        check32("drain_left", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [2:0]  lvl;
        int          mode;
        logic [23:0] fill;
        int          bad_idx;
        logic [23:0] bad_val;
        logic [63:0] exp_w0;
        logic [63:0] exp_w1;
        int          exp_words;
        bit          exp_err;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   cyc;
        int   idx;
        int   n;
        int   rst_at;
        int   r;
        int   mx;
        logic [2:0] plvl;

        rst     = 1'b1;
        sec_lvl = 3'd0;
        valid_i = 1'b0;
        di      = '0;
        ready_o = 1'b0;

        vecs[0] = '{3'd3, 1, 24'd0,     -1,  24'd0,  64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 16, 1'b0};
        vecs[1] = '{3'd2, 0, 24'd1,     -1,  24'd0,  64'h1041041041041041, 64'h4104104104104104, 24, 1'b0};
        vecs[2] = '{3'd3, 1, 24'd0,     5,   24'd16, 64'hFEDCBA9876043210, 64'hFEDCBA9876543210, 16, 1'b1};
        vecs[3] = '{3'd5, 0, 24'd15,    -1,  24'd0,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 16, 1'b0};
        vecs[4] = '{3'd2, 0, 24'd43,    -1,  24'd0,  64'hBAEBAEBAEBAEBAEB, 64'hEBAEBAEBAEBAEBAE, 24, 1'b0};
        vecs[5] = '{3'd3, 0, 24'h0001F3, -1, 24'd0,  64'h3333333333333333, 64'h3333333333333333, 16, 1'b1};
        vecs[6] = '{3'd7, 0, 24'd1,     -1,  24'd0,  64'h1041041041041041, 64'h4104104104104104, 24, 1'b1};
        vecs[7] = '{3'd2, 0, 24'd0,     0,   24'd44, 64'h000000000000002C, 64'h0000000000000000, 24, 1'b1};
        vecs[8] = '{3'd3, 0, 24'd15,    255, 24'd16, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 16, 1'b1};

        // Whole-polynomial vectors with valid_i and ready_o held high.
        foreach (vecs[v]) begin
            apply_reset();
            check_reset_vals();
            set_poly(vecs[v].lvl, vecs[v].mode, vecs[v].fill);
            if (vecs[v].bad_idx >= 0) coefs[vecs[v].bad_idx] = vecs[v].bad_val;
            clear_stats();
            feed(0, 1'b0, 1'b0, cyc);
            check32("accept_cycles", cyc, 256 + vecs[v].exp_words - 1);
            drain();
            check64("vec_word0", out_w0, vecs[v].exp_w0);
            check64("vec_word1", out_w1, vecs[v].exp_w1);
            check32("vec_words", out_count, vecs[v].exp_words);
            check32("vec_last_count", last_count, 1);
            check32("vec_last_pos", last_pos, vecs[v].exp_words - 1);
            check1("vec_err", err_o, vecs[v].exp_err);
        end

        // First-word latency: 16 accepts, one stall, then the word.
        apply_reset();
        set_poly(3'd3, 1, 24'd0);
        clear_stats();
        idx = 0;
        repeat (16) step(idx, 1'b0, 1'b0, 1'b1);
        #1;
        check32("lat_accepts", idx, 16);
        check1("lat_ready_stall", ready_i, 1'b0);
        check1("lat_valid_pre", valid_o, 1'b0);
        step(idx, 1'b0, 1'b0, 1'b1);
        #1;
        check1("lat_valid", valid_o, 1'b1);
        check1("lat_ready_back", ready_i, 1'b1);
        check64("lat_word", do_o, 64'hFEDCBA9876543210);
        feed(idx, 1'b0, 1'b0, cyc);
        drain();
        check32("lat_words", out_count, 16);

        // Backpressure while word 1 sits on the output.
        apply_reset();
        set_poly(3'd2, 0, 24'd1);
        clear_stats();
        idx = 0;
        n   = 0;
        while (out_count < 1 && n < 200) begin
            step(idx, 1'b0, 1'b0, 1'b1);
            n++;
        end
        check32("bp_first_word", out_count, 1);
        repeat (30) step(idx, 1'b0, 1'b0, 1'b0);
        #1;
        check1("bp_valid_held", valid_o, 1'b1);
        check1("bp_ready_low", ready_i, 1'b0);
        check64("bp_word1", do_o, 64'h4104104104104104);
        feed(idx, 1'b0, 1'b0, cyc);
        drain();
        check32("bp_words", out_count, 24);
        check32("bp_last_pos", last_pos, 23);

        // Reset after 100 coefficients, then a clean level-3 polynomial.
        apply_reset();
        set_poly(3'd2, 0, 24'd7);
        idx = 0;
        n   = 0;
        while (idx < 100 && n < 300) begin
            step(idx, 1'b0, 1'b0, 1'b1);
            n++;
        end
        apply_reset();
        check_reset_vals();
        set_poly(3'd3, 1, 24'd0);
        clear_stats();
        feed(0, 1'b0, 1'b0, cyc);
        drain();
        check64("mid_rst_word0", out_w0, 64'hFEDCBA9876543210);
        check32("mid_rst_words", out_count, 16);

        // Level change mid-polynomial is ignored; the next polynomial picks it up.
        apply_reset();
        set_poly(3'd3, 1, 24'd0);
        for (int i = 50; i < 256; i++) lvls[i] = 3'd2;
        clear_stats();
        feed(0, 1'b1, 1'b1, cyc);
        drain();
        check32("lvl_chg_words_a", out_count, 16);
        check64("lvl_chg_word0", out_w0, 64'hFEDCBA9876543210);
        set_poly(3'd2, 1, 24'd0);
        clear_stats();
        feed(0, 1'b1, 1'b1, cyc);
        drain();
        check32("lvl_chg_words_b", out_count, 24);
        check1("lvl_chg_err", err_o, 1'b0);

        // Random back-to-back polynomials with random flow control and occasional resets.
        apply_reset();
        for (int p = 0; p < 10; p++) begin
            r    = $urandom_range(0, 9);
            plvl = (r < 4) ? 3'd2 : (r < 7) ? 3'd3 : (r < 9) ? 3'd5 : 3'd7;
            mx   = (plvl == 3'd3 || plvl == 3'd5) ? 15 : 43;
            for (int i = 0; i < 256; i++) begin
                coefs[i] = ($urandom_range(0, 49) == 0) ? 24'($urandom) : 24'($urandom_range(0, mx));
                lvls[i]  = (i == 0) ? plvl : 3'($urandom_range(0, 7));
            end
            rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 255)) : -1;
            idx = 0;
            n   = 0;
            while (idx < 256 && n < 5000) begin
                if (idx == rst_at) begin
                    apply_reset();
                    rst_at = -1;
                    idx    = 0;
                end
                step(idx, 1'b1, 1'b1, 1'b1);
                n++;
            end
            check32("rand_feed", idx, 256);
        end
        valid_i = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
